// File: rtl/dmem_pkg.sv
// Shared types and default sizing for the data memory model.
package dmem_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_DONE
   } dmem_state_t;

   localparam int DEF_BLOCK_SIZE   = 2;
   localparam int DEF_LINE_SIZE    = 32;
   localparam int DEF_ADDRESS_SIZE = 32;
   localparam int DEF_MEM_INDEX    = 8;
   localparam int DEF_MEM_LATENCY  = 4;
   localparam int LAT_W            = 4;

endpackage

// File: rtl/dmemory_if.sv
// Cache-to-memory block bus: request, address, block data and completion pulses.
interface dmemory_if
   import dmem_pkg::*;
#(
   parameter int c_block_size = DEF_BLOCK_SIZE,
   parameter int c_line_size  = DEF_LINE_SIZE,
   parameter int address_size = DEF_ADDRESS_SIZE
);
   localparam int BLK_W  = (2 ** c_block_size) * c_line_size;
   localparam int ADDR_W = address_size - c_block_size - 2;

   logic              read;
   logic              write;
   logic [ADDR_W-1:0] address;
   logic [BLK_W-1:0]  writedata;
   logic [BLK_W-1:0]  readdata;
   logic              busywait;
   logic              read_done;
   logic              write_done;

   modport master (
      output read, write, address, writedata,
      input  readdata, busywait, read_done, write_done
   );

   modport slave (
      input  read, write, address, writedata,
      output readdata, busywait, read_done, write_done
   );

endinterface

// File: rtl/dmem_array.sv
// Block storage: one port, synchronous read or write of a whole block per cycle.
module dmem_array #(
   parameter int width      = 128,
   parameter int depth_log2 = 8
) (
   input  logic                  clock,
   input  logic                  en,
   input  logic                  we,
   input  logic [depth_log2-1:0] addr,
   input  logic [width-1:0]      wdata,
   output logic [width-1:0]      rdata
);

   logic [width-1:0] mem [2 ** depth_log2];

   // NOTE: storage and its read register carry no reset so they map onto RAM macros.
   always_ff @(posedge clock) begin
      if (en) begin
         if (we) mem[addr] <= wdata;
         else    rdata     <= mem[addr];
      end
   end

endmodule

// File: rtl/dmemory.sv
// Multi-cycle block data memory behind a data cache; DMEMORY_STATS_EN adds access counters.
module dmemory
   import dmem_pkg::*;
#(
   parameter int c_block_size = DEF_BLOCK_SIZE,
   parameter int c_line_size  = DEF_LINE_SIZE,
   parameter int address_size = DEF_ADDRESS_SIZE,
   parameter int mem_index    = DEF_MEM_INDEX,
   parameter int mem_latency  = DEF_MEM_LATENCY
) (
   input  logic       clock,
   input  logic       reset,
   dmemory_if.slave   bus
`ifdef DMEMORY_STATS_EN
   ,
   output logic [31:0] read_count,
   output logic [31:0] write_count
`endif
);

   localparam int BLK_W = (2 ** c_block_size) * c_line_size;

   dmem_state_t          state;
   logic [LAT_W-1:0]     count;
   logic [mem_index-1:0] addr_q;
   logic [BLK_W-1:0]     wdata_q;
   logic                 rd_valid;
   logic                 read_done_q;
   logic                 write_done_q;
   logic                 access;
   logic [BLK_W-1:0]     arr_rdata;

   // The access edge is suppressed while reset is low so an aborted write never lands.
   assign access = reset && (count == '0) && (state == S_READ || state == S_WRITE);

   dmem_array #(
      .width      (BLK_W),
      .depth_log2 (mem_index)
   ) u_array (
      .clock (clock),
      .en    (access),
      .we    (state == S_WRITE),
      .addr  (addr_q),
      .wdata (wdata_q),
      .rdata (arr_rdata)
   );

   // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state        <= S_IDLE;
         count        <= '0;
         rd_valid     <= 1'b0;
         read_done_q  <= 1'b0;
         write_done_q <= 1'b0;
      end else begin
         read_done_q  <= 1'b0;
         write_done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.write || bus.read) begin
                  state   <= bus.write ? S_WRITE : S_READ;
                  addr_q  <= bus.address[mem_index-1:0];
                  wdata_q <= bus.writedata;
                  count   <= LAT_W'(mem_latency - 1);
               end
            end
            S_READ, S_WRITE: begin
               if (count == '0) begin
                  state <= S_DONE;
                  if (state == S_READ) begin
                     read_done_q <= 1'b1;
                     rd_valid    <= 1'b1;
                  end else begin
                     write_done_q <= 1'b1;
                  end
               end else begin
                  count <= count - 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Array read register holds the last refill; rd_valid gives it a reset value of zero.
   assign bus.readdata   = rd_valid ? arr_rdata : '0;
   assign bus.read_done  = read_done_q;
   assign bus.write_done = write_done_q;
   assign bus.busywait   = (state == S_READ) || (state == S_WRITE) ||
                           ((state == S_IDLE) && (bus.read || bus.write));

`ifdef DMEMORY_STATS_EN
   always_ff @(posedge clock) begin
      if (!reset) begin
         read_count  <= '0;
         write_count <= '0;
      end else begin
         if (read_done_q && (read_count != '1))   read_count  <= read_count + 1'b1;
         if (write_done_q && (write_count != '1)) write_count <= write_count + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_dmemory.sv
// Scoreboard bench for dmemory; define DMEMORY_STATS_EN to also exercise the counters.
module tb_dmemory;
   import dmem_pkg::*;

   localparam int BLK_W  = 128;
   localparam int ADDR_W = 28;
   localparam logic [BLK_W-1:0] D1 = 128'hDDDD_CCCC_BBBB_AAAA_9999_8888_7777_6666;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   dmemory_if bus ();

`ifdef DMEMORY_STATS_EN
   logic [31:0] read_count;
   logic [31:0] write_count;
`endif

   dmemory dut (
      .clock       (clock),
      .reset       (reset),
      .bus         (bus)
`ifdef DMEMORY_STATS_EN
      ,
      .read_count  (read_count),
      .write_count (write_count)
`endif
   );

   typedef struct packed {
      logic             is_wr;
      logic [BLK_W-1:0] data;
   } exp_t;

   exp_t sb[$];
   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [BLK_W-1:0] got, input logic [BLK_W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Monitor: every completion pulse is matched against the oldest expected response.
   always @(negedge clock) begin : monitor
      exp_t e;
      if (bus.read_done === 1'b1 || bus.write_done === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_done", {bus.write_done, bus.read_done}, 0);
         end else begin
            e = sb.pop_front();
            check("done_kind", {bus.write_done, bus.read_done}, e.is_wr ? 2'b10 : 2'b01);
            if (!e.is_wr) check("readdata", bus.readdata, e.data);
         end
      end
   end

   task automatic expect_op(input logic is_wr, input logic [BLK_W-1:0] data);
      sb.push_back('{is_wr: is_wr, data: data});
   endtask

   task automatic issue(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                        input logic [BLK_W-1:0] d);
      bus.read      = rd;
      bus.write     = wr;
      bus.address   = a;
      bus.writedata = d;
   endtask

   task automatic wait_done(input string name, input int exp_cyc);
      int  n    = 0;
      bit  seen = 1'b0;
      for (int i = 1; i <= 40 && !seen; i++) begin
         @(negedge clock);
         if (bus.read_done === 1'b1 || bus.write_done === 1'b1) begin
            seen = 1'b1;
            n    = i;
         end
      end
      check({name, "_latency"}, n, exp_cyc);
   endtask

   task automatic do_op(input string name, input logic wr, input logic [ADDR_W-1:0] a,
                        input logic [BLK_W-1:0] d, input logic [BLK_W-1:0] expd);
      expect_op(wr, expd);
      issue(!wr, wr, a, d);
      wait_done(name, 5);
      bus.read  = 1'b0;
      bus.write = 1'b0;
      @(negedge clock);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      issue(1'b0, 1'b0, '0, '0);
      repeat (3) @(negedge clock);
      check("rst_readdata", bus.readdata, 0);
      check("rst_read_done", bus.read_done, 0);
      check("rst_write_done", bus.write_done, 0);
      check("rst_busywait", bus.busywait, 0);
      reset = 1'b1;
      @(negedge clock);

      do_op("wr4", 1'b1, 28'h4, D1, '0);
      do_op("rd4", 1'b0, 28'h4, '0, D1);

      // Simultaneous read and write: write-back first, held read accepted after DONE.
      expect_op(1'b1, '0);
      expect_op(1'b0, 128'h1234);
      issue(1'b1, 1'b1, 28'h10, 128'h1234);
      wait_done("both_wr", 5);
      bus.write = 1'b0;
      check("busy_in_done", bus.busywait, 0);
      @(negedge clock);
      check("busy_idle_req", bus.busywait, 1);
      wait_done("both_rd", 5);
      bus.read = 1'b0;
      @(negedge clock);

      // Read held through DONE is re-accepted only in the following IDLE cycle.
      expect_op(1'b0, D1);
      expect_op(1'b0, D1);
      issue(1'b1, 1'b0, 28'h4, '0);
      wait_done("hold_rd1", 5);
      check("busy_in_done2", bus.busywait, 0);
      @(negedge clock);
      check("busy_idle_req2", bus.busywait, 1);
      wait_done("hold_rd2", 5);
      bus.read = 1'b0;
      @(negedge clock);

      // Inputs changed mid-read must not alter the access.
      expect_op(1'b0, D1);
      issue(1'b1, 1'b0, 28'h4, '0);
      repeat (2) @(negedge clock);
      bus.address   = 28'h10;
      bus.writedata = 128'hBAD;
      bus.read      = 1'b0;
      wait_done("midchg", 3);
      @(negedge clock);

      // Reset in the second WRITE cycle aborts the write.
      do_op("wr20_pre", 1'b1, 28'h20, 128'h5A, '0);
      issue(1'b0, 1'b1, 28'h20, 128'hFF);
      repeat (2) @(negedge clock);
      reset     = 1'b0;
      bus.write = 1'b0;
      @(negedge clock);
      check("abort_readdata", bus.readdata, 0);
      check("abort_read_done", bus.read_done, 0);
      check("abort_write_done", bus.write_done, 0);
      check("abort_busywait", bus.busywait, 0);
      reset = 1'b1;
      repeat (8) @(negedge clock);
      do_op("rd20", 1'b0, 28'h20, '0, 128'h5A);

      // Upper address bits alias onto the same block.
      do_op("wr100", 1'b1, 28'h100, 128'hAB, '0);
      do_op("rd000", 1'b0, 28'h000, '0, 128'hAB);

`ifdef DMEMORY_STATS_EN
      reset = 1'b0;
      @(negedge clock);
      check("stats_rst_rd", read_count, 0);
      check("stats_rst_wr", write_count, 0);
      reset = 1'b1;
      @(negedge clock);
      do_op("st_w1", 1'b1, 28'h4, D1, '0);
      do_op("st_r1", 1'b0, 28'h4, '0, D1);
      do_op("st_w2", 1'b1, 28'h8, 128'h77, '0);
      do_op("st_r2", 1'b0, 28'h8, '0, 128'h77);
      do_op("st_r3", 1'b0, 28'h4, '0, D1);
      check("stats_rd", read_count, 3);
      check("stats_wr", write_count, 2);
      reset = 1'b0;
      @(negedge clock);
      check("stats_clr_rd", read_count, 0);
      check("stats_clr_wr", write_count, 0);
      reset = 1'b1;
      @(negedge clock);
`endif

      check("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dmemory.md
DMEMORY -- requirements
Module: dmemory

Interface
REQ-001 SHALL have parameter c_block_size, default 2, log2 of 32-bit words per block (4 words).
REQ-002 SHALL have parameter c_line_size, default 32, word width in bits.
REQ-003 SHALL have parameter address_size, default 32, byte-address width.
REQ-004 SHALL have parameter mem_index, default 8, log2 of stored blocks (256).
REQ-005 SHALL have parameter mem_latency, default 4, array-access cycles, legal range 1..15.
REQ-006 SHALL have port clock  in  1  single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-008 SHALL have port read  in  1  block read request from data cache.
REQ-009 SHALL have port write  in  1  block write-back request from data cache.
REQ-010 SHALL have port address  in  address_size-c_block_size-2  block address.
REQ-011 SHALL have port writedata  in  2**c_block_size*c_line_size  write-back block.
REQ-012 SHALL have port readdata  out  2**c_block_size*c_line_size  refill block, registered.
REQ-013 SHALL have port busywait  out  1  access in progress.
REQ-014 SHALL have ports read_done and write_done  out  1 each  one-cycle completion pulses.

Function
REQ-015 SHALL implement FSM IDLE, READ, WRITE, DONE.
REQ-016 IDLE: write=1 -> WRITE (write wins even if read=1); else read=1 -> READ; else stay.
REQ-017 On leaving IDLE, SHALL latch address, writedata and load latency counter with mem_latency-1.
REQ-018 READ/WRITE: counter decrements each cycle; at 0 the array access occurs at that edge and FSM -> DONE.
REQ-019 Read access SHALL load readdata from block address[mem_index-1:0]; readdata held until next completed read.
REQ-020 Write access SHALL store the latched block at address[mem_index-1:0]; upper address bits ignored (aliasing).
REQ-021 DONE: one cycle; read_done or write_done =1 matching the completed access; -> IDLE unconditionally; no request accepted in DONE.
REQ-022 busywait SHALL be combinational: 1 in IDLE with read|write, 1 in READ/WRITE, 0 in DONE and idle-no-request.
REQ-023 Latency: request first high in cycle 0 -> done pulse in cycle mem_latency+1.
REQ-024 Requester holding read after a write_done SHALL be accepted in the following IDLE cycle (write-back then refill).
REQ-025 Input changes during READ/WRITE SHALL not affect the access in progress.

Reset
REQ-026 reset=0 at a rising edge SHALL force IDLE, counter 0, readdata 0, read_done 0, write_done 0.
REQ-027 Reset mid-WRITE SHALL abort without modifying the array; reset mid-READ produces no read_done.
REQ-028 Array contents SHALL not be cleared by reset.

Configuration
REQ-029 Macro DMEMORY_STATS_EN defined: extra outputs read_count, write_count (32-bit, saturating at 0xFFFFFFFF), incremented on each read_done/write_done, cleared by reset.
REQ-030 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-031 Package dmem_pkg SHALL hold FSM state typedef and default parameter constants.
REQ-032 Storage SHALL be a sub-module dmem_array (synchronous one-port block read/write, no reset).

Verification
REQ-033 Write 0x0000_0004 / data 0xDDDD_CCCC_BBBB_AAAA_9999_8888_7777_6666 -> write_done in cycle 5; then read same address -> read_done cycle 5, readdata equals written block.
REQ-034 read=1 and write=1 together, address 0x10, data 0x1234 -> write_done first, then read_done with readdata 0x1234.
REQ-035 Write address 0x20 data 0xFF, reset=0 in second WRITE cycle -> no write_done, outputs zero; later read 0x20 returns prior contents.
REQ-036 read held high through DONE -> no second acceptance in DONE; busywait=0 in DONE, 1 again next IDLE cycle.
REQ-037 Write address 0x100 data 0xAB, read address 0x000 -> readdata 0xAB (aliasing with mem_index=8).
REQ-038 With DMEMORY_STATS_EN: 3 reads, 2 writes -> read_count=3, write_count=2; reset clears both to 0.
